// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction memory,
// and fills the F/D latch. It squashes wrong-path fetches on redirect and holds state on stall.
module fetch_unit #(
  parameter int              AW  = 12,
  parameter int              IW  = 32,
  parameter logic [IW-1:0]   NOP = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_target,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] fd_insn,
  output logic [AW-1:0] fd_pc,
  output logic          fd_valid,
  output logic [15:0]   squash_count
);

  localparam logic [0:0]    FILL   = 1'b0;
  localparam logic [0:0]    STREAM = 1'b1;
  localparam logic [AW-1:0] PC_ONE = AW'(1);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] inflight_pc_q, inflight_pc_d;
  logic [IW-1:0] fd_insn_q, fd_insn_d;
  logic [AW-1:0] fd_pc_q, fd_pc_d;
  logic          fd_valid_q, fd_valid_d;
  logic [15:0]   squash_q, squash_d;
  logic          inflight;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign inflight = (state_q == STREAM);

  // While stalled, re-present the in-flight address so imem_data keeps returning that word.
  assign imem_addr = redirect_valid        ? redirect_target :
                     (stall && inflight)   ? inflight_pc_q   : pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    fd_insn_d     = fd_insn_q;
    fd_pc_d       = fd_pc_q;
    fd_valid_d    = fd_valid_q;
    squash_d      = squash_q;
    if (redirect_valid) begin
      pc_d          = redirect_target + PC_ONE;
      state_d       = STREAM;
      inflight_pc_d = redirect_target;
      fd_insn_d     = NOP;
      fd_valid_d    = 1'b0;
      fd_pc_d       = '0;
      if (inflight) squash_d = sat_inc(squash_q);
    end else if (!stall) begin
      fd_insn_d     = inflight ? imem_data : NOP;
      fd_valid_d    = inflight;
      fd_pc_d       = inflight ? inflight_pc_q + PC_ONE : '0;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + PC_ONE;
      state_d       = STREAM;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FILL;
      pc_q          <= '0;
      inflight_pc_q <= '0;
      fd_insn_q     <= NOP;
      fd_pc_q       <= '0;
      fd_valid_q    <= 1'b0;
      squash_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      fd_insn_q     <= fd_insn_d;
      fd_pc_q       <= fd_pc_d;
      fd_valid_q    <= fd_valid_d;
      squash_q      <= squash_d;
    end
  end

  assign fd_insn      = fd_insn_q;
  assign fd_pc        = fd_pc_q;
  assign fd_valid     = fd_valid_q;
  assign squash_count = squash_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a one-cycle-latency memory returning A000_0000+addr,
// a vector table for streaming/redirect/stall/wrap/reset, and a squash-saturation sequence.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [11:0] redirect_target;
  logic [11:0] imem_addr;
  logic [31:0] imem_data = 32'd0;
  logic [31:0] fd_insn;
  logic [11:0] fd_pc;
  logic        fd_valid;
  logic [15:0] squash_count;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .fd_insn         (fd_insn),
    .fd_pc           (fd_pc),
    .fd_valid        (fd_valid),
    .squash_count    (squash_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) imem_data <= 32'hA000_0000 + {20'd0, imem_addr};

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rv;
    logic [11:0] tgt;
    logic [11:0] addr;
    logic        vld;
    logic [31:0] insn;
    logic [11:0] pc;
    logic [15:0] sq;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic rst, logic stl, logic rv, logic [11:0] tgt,
                              logic [11:0] addr, logic vld, logic [31:0] insn,
                              logic [11:0] pc, logic [15:0] sq);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rv = rv; v.tgt = tgt; v.addr = addr;
    v.vld = vld; v.insn = insn; v.pc = pc; v.sq = sq;
    return v;
  endfunction

  function automatic logic [31:0] w(logic [11:0] a);
    return 32'hA000_0000 + {20'd0, a};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //                rst stl rv tgt      addr     vld  insn        pc       sq
    tbl[0]  = mk(0, 0, 0, 12'h000, 12'h000, 0, 32'd0,        12'h000, 16'd0);
    tbl[1]  = mk(0, 0, 0, 12'h000, 12'h001, 1, w(12'h000),   12'h001, 16'd0);
    tbl[2]  = mk(0, 0, 0, 12'h000, 12'h002, 1, w(12'h001),   12'h002, 16'd0);
    tbl[3]  = mk(0, 0, 0, 12'h000, 12'h003, 1, w(12'h002),   12'h003, 16'd0);
    tbl[4]  = mk(0, 0, 0, 12'h000, 12'h004, 1, w(12'h003),   12'h004, 16'd0);
    tbl[5]  = mk(0, 0, 1, 12'h100, 12'h100, 0, 32'd0,        12'h000, 16'd1);
    tbl[6]  = mk(0, 0, 0, 12'h000, 12'h101, 1, w(12'h100),   12'h101, 16'd1);
    tbl[7]  = mk(0, 0, 0, 12'h000, 12'h102, 1, w(12'h101),   12'h102, 16'd1);
    tbl[8]  = mk(0, 1, 0, 12'h000, 12'h102, 1, w(12'h101),   12'h102, 16'd1);
    tbl[9]  = mk(0, 1, 0, 12'h000, 12'h102, 1, w(12'h101),   12'h102, 16'd1);
    tbl[10] = mk(0, 1, 0, 12'h000, 12'h102, 1, w(12'h101),   12'h102, 16'd1);
    tbl[11] = mk(0, 0, 0, 12'h000, 12'h103, 1, w(12'h102),   12'h103, 16'd1);
    tbl[12] = mk(0, 0, 0, 12'h000, 12'h104, 1, w(12'h103),   12'h104, 16'd1);
    tbl[13] = mk(0, 1, 1, 12'h040, 12'h040, 0, 32'd0,        12'h000, 16'd2);
    tbl[14] = mk(0, 0, 0, 12'h000, 12'h041, 1, w(12'h040),   12'h041, 16'd2);
    tbl[15] = mk(0, 0, 1, 12'hFFE, 12'hFFE, 0, 32'd0,        12'h000, 16'd3);
    tbl[16] = mk(0, 0, 0, 12'h000, 12'hFFF, 1, w(12'hFFE),   12'hFFF, 16'd3);
    tbl[17] = mk(0, 0, 0, 12'h000, 12'h000, 1, w(12'hFFF),   12'h000, 16'd3);
    tbl[18] = mk(0, 0, 0, 12'h000, 12'h001, 1, w(12'h000),   12'h001, 16'd3);
    tbl[19] = mk(1, 0, 0, 12'h000, 12'h002, 0, 32'd0,        12'h000, 16'd0);
    tbl[20] = mk(0, 0, 1, 12'h200, 12'h200, 0, 32'd0,        12'h000, 16'd0);
    tbl[21] = mk(0, 0, 0, 12'h000, 12'h201, 1, w(12'h200),   12'h201, 16'd0);

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 12'h000;
    tick();
    tick();
    chk("rst_valid", 0, {31'd0, fd_valid}, 32'd0);
    chk("rst_insn",  0, fd_insn, 32'd0);
    chk("rst_pc",    0, {20'd0, fd_pc}, 32'd0);
    chk("rst_sq",    0, {16'd0, squash_count}, 32'd0);
    chk("rst_addr",  0, {20'd0, imem_addr}, 32'd0);

    for (int i = 0; i < 22; i++) begin
      reset = tbl[i].rst; stall = tbl[i].stl;
      redirect_valid = tbl[i].rv; redirect_target = tbl[i].tgt;
      #1;
      chk("imem_addr", i, {20'd0, imem_addr}, {20'd0, tbl[i].addr});
      tick();
      chk("fd_valid", i, {31'd0, fd_valid}, {31'd0, tbl[i].vld});
      chk("fd_insn",  i, fd_insn, tbl[i].insn);
      chk("fd_pc",    i, {20'd0, fd_pc}, {20'd0, tbl[i].pc});
      chk("squash",   i, {16'd0, squash_count}, {16'd0, tbl[i].sq});
    end

    // Saturation: first redirect after reset squashes nothing, then every redirect squashes one.
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 12'h000;
    tick();
    reset = 1'b0; redirect_valid = 1'b1; redirect_target = 12'h300;
    tick();
    chk("sat_first", 0, {16'd0, squash_count}, 32'd0);
    for (int i = 0; i < 65534; i++) begin
      redirect_target = 12'(i);
      tick();
    end
    chk("sat_fffe", 0, {16'd0, squash_count}, 32'h0000_FFFE);
    tick();
    chk("sat_ffff", 0, {16'd0, squash_count}, 32'h0000_FFFF);
    tick();
    tick();
    tick();
    chk("sat_hold", 0, {16'd0, squash_count}, 32'h0000_FFFF);
    redirect_valid = 1'b0;
    tick();
    tick();
    chk("sat_after_valid", 0, {31'd0, fd_valid}, 32'd1);
    chk("sat_after_sq", 0, {16'd0, squash_count}, 32'h0000_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined processor. It owns the 12-bit program counter, drives the synchronous instruction memory, and fills the F/D pipeline latch with the fetched word and its PC+1. It is the consumer end of the next-PC path: the execute-stage next-PC logic sends taken-branch/jump targets here as redirect requests, and this block squashes the wrong-path fetch and restarts at the target. It also honours decode-stage stalls without losing the in-flight word.

## Interface
Parameters:
- AW, 12, PC / instruction-memory address width
- IW, 32, instruction width
- NOP, 32'd0, word injected into F/D on a bubble

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold PC and F/D latch this cycle
- redirect_valid  in  1  execute stage: taken branch or jump this cycle
- redirect_target  in  AW  new PC when redirect_valid=1
- imem_addr  out  AW  instruction-memory address (combinational)
- imem_data  in  IW  memory word for the address presented in the previous cycle
- fd_insn  out  IW  F/D latch: instruction
- fd_pc  out  AW  F/D latch: address of fd_insn plus 1, mod 2^AW
- fd_valid  out  1  F/D latch holds a real instruction (0 = bubble)
- squash_count  out  16  saturating count of squashed wrong-path fetches

## Operation
- Registers: pc (next address to fetch), inflight (a fetch was issued last cycle and is still valid), inflight_pc (its address), F/D latch, squash_count.
- FSM on inflight: FILL (inflight=0) and STREAM (inflight=1). FILL -> STREAM on any non-reset cycle that issues a fetch. Only reset returns to FILL.
- imem_addr priority: redirect_valid ? redirect_target : (stall & inflight) ? inflight_pc : pc. Re-presenting inflight_pc during a stall keeps imem_data equal to the in-flight word on every stall cycle.
- Per-cycle update, in priority order:
  - reset: pc=0, inflight=0, inflight_pc=0, fd_insn=NOP, fd_pc=0, fd_valid=0, squash_count=0.
  - redirect_valid, whether or not stall is asserted: pc <= target+1; inflight <= 1; inflight_pc <= target; fd_insn <= NOP; fd_valid <= 0; fd_pc <= 0. If inflight=1, squash_count increments, saturating at 16'hFFFF.
  - stall: pc, inflight, inflight_pc and the F/D latch hold.
  - otherwise: fd_insn <= inflight ? imem_data : NOP; fd_valid <= inflight; fd_pc <= inflight ? inflight_pc+1 : 0; inflight_pc <= pc; pc <= pc+1; inflight <= 1.
- Arithmetic: all PC increments are AW-bit and wrap (12'hFFF + 1 = 12'h000). There is no carry-out.
- No instruction decode is done here.

## Timing
- Memory latency is 1 cycle: the address presented in cycle N returns on imem_data in cycle N+1.
- After reset deasserts:
  - cycle 0: imem_addr=0
  - cycle 1: imem_addr=1
  - end of cycle 1: F/D = {word(0), fd_pc=1, valid}
- Steady state is one instruction per cycle.
- A redirect in cycle N inserts exactly one bubble:
  - F/D after edge N is a bubble.
  - F/D after edge N+1 is word(target) with fd_pc=target+1.
- A stall for k cycles freezes the F/D outputs for k cycles. The next instruction follows on the first unstalled cycle with no loss and no duplication.
- Redirect and stall in the same cycle: redirect wins and F/D becomes a bubble.
- Reset mid-stream: everything clears at the next edge, and in-flight data is discarded.

## Test plan
- Reset, then run 5 cycles with no stall or redirect; memory holds word(a)=32'hA000_0000+a. Required: fd_valid=0 during reset; F/D after edges 1..4 = (32'hA000_0000, pc 1), (…0001, 2), (…0002, 3), (…0003, 4).
- Redirect to 12'h100 while streaming at pc=12'h005. Required: next F/D is a bubble (NOP, valid=0); the following F/D is (word(0x100), 12'h101); squash_count=1.
- Stall held 3 cycles in mid-stream. Required: F/D frozen for 3 cycles; imem_addr equals inflight_pc during the stall; after release the sequence continues with no skipped or repeated pc.
- Stall and redirect (target 12'h040) asserted together. Required: bubble in F/D, then (word(0x040), 12'h041).
- Wrap-around: redirect to 12'hFFE. Required: subsequent F/D pcs are 12'hFFF, 12'h000, 12'h001, with imem_addr wrapping to 0.
- Redirect in the first cycle after reset (inflight=0). Required: bubble, then word(target); squash_count stays 0. Separately, force 65536 squashes. Required: squash_count saturates at 16'hFFFF.
